serial_line_tx: RTL and testbench

SERIAL_LINE_TX -- requirements
Module: serial_line_tx

---
 rtl/serial_line_tx_if.sv | 22 ++
 rtl/serial_line_tx.sv | 112 +++++++++++
 tb/tb_serial_line_tx.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_line_tx_if.sv
// Frame request, payload and serial line status bundle for serial_line_tx.
// master drives the request/payload side; slave is the transmitter.
interface serial_line_tx_if;
  logic         start;
  logic [15:0]  handshake_i;
  logic [944:0] nums;
  logic [15:0]  handshake_f;
  logic         out;
  logic         trig_out;
  logic         busy;
  logic         done;

  modport master (
    output start, handshake_i, nums, handshake_f,
    input  out, trig_out, busy, done
  );

  modport slave (
    input  start, handshake_i, nums, handshake_f,
    output out, trig_out, busy, done
  );
endinterface

// File: rtl/serial_line_tx.sv
// Sends {handshake_i, nums, handshake_f} MSB first at BIT_CLKS clocks per bit, then N_PAD low bits.
// First bit and trig_out appear one clock after start is taken; start is ignored while busy (no queuing).
module serial_line_tx #(
  parameter int BIT_CLKS = 1000,
  parameter int N_PAD    = 2
) (
  input  logic            clk_in,
  input  logic            rst,
  serial_line_tx_if.slave bus
);
  localparam int         FRAME_BITS = 977;
  localparam logic [15:0] CNT_LAST  = 16'(BIT_CLKS - 1);
  localparam logic [9:0]  BIT_LAST  = 10'(FRAME_BITS - 1);
  localparam logic [9:0]  PAD_LAST  = (N_PAD > 0) ? 10'(N_PAD - 1) : 10'd0;

  typedef enum logic [1:0] {IDLE, SEND, PAD} state_t;

  state_t                state, state_nxt;
  logic [15:0]           cnt, cnt_nxt;
  logic [9:0]            bit_idx, bit_nxt;
  logic [FRAME_BITS-1:0] shreg, shreg_nxt;
  logic                  trig_q, trig_nxt;
  logic                  busy_q, busy_nxt;
  logic                  done_q, done_nxt;
  logic                  wrap;

  assign wrap = (cnt == CNT_LAST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    bit_nxt   = bit_idx;
    shreg_nxt = shreg;
    trig_nxt  = 1'b0;
    busy_nxt  = busy_q;
    done_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        busy_nxt = 1'b0;
        if (bus.start) begin
          shreg_nxt = {bus.handshake_i, bus.nums, bus.handshake_f};
          cnt_nxt   = '0;
          bit_nxt   = '0;
          trig_nxt  = 1'b1;
          busy_nxt  = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        cnt_nxt = wrap ? 16'd0 : cnt + 16'd1;
        if (wrap) begin
          // The line is the shift register MSB, so the last shift leaves it all zero for PAD/IDLE.
          shreg_nxt = {shreg[FRAME_BITS-2:0], 1'b0};
          if (bit_idx == BIT_LAST) begin
            bit_nxt = '0;
            if (N_PAD == 0) begin
              state_nxt = IDLE;
              busy_nxt  = 1'b0;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = PAD;
            end
          end else begin
            bit_nxt = bit_idx + 10'd1;
          end
        end
      end
      PAD: begin
        cnt_nxt = wrap ? 16'd0 : cnt + 16'd1;
        if (wrap) begin
          if (bit_idx == PAD_LAST) begin
            bit_nxt   = '0;
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            bit_nxt = bit_idx + 10'd1;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      trig_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_nxt;
      shreg   <= shreg_nxt;
      trig_q  <= trig_nxt;
      busy_q  <= busy_nxt;
      done_q  <= done_nxt;
    end
  end

  assign bus.out      = shreg[FRAME_BITS-1];
  assign bus.trig_out = trig_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
endmodule

// File: tb/tb_serial_line_tx.sv
// Random-payload scoreboard bench for serial_line_tx: model queues expected frames, monitor checks the line.
module tb_serial_line_tx;
  localparam int BC    = 4;
  localparam int NP    = 2;
  localparam int NBITS = 977 + NP;
  localparam int TOTAL = NBITS * BC;

  typedef struct {
    logic [NBITS-1:0] bits;
    int               acc_edge;
  } exp_t;

  logic clk_in = 1'b0;
  logic rst;
  serial_line_tx_if bus ();

  serial_line_tx #(.BIT_CLKS(BC), .N_PAD(NP)) dut (
    .clk_in (clk_in),
    .rst    (rst),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int   n_checks = 0;
  int   n_pass = 0;
  int   edge_no = 0;
  int   free_at = 0;
  int   frames_pushed = 0;
  int   frames_seen = 0;
  int   idle_bad = 0;
  bit   active = 1'b0;
  exp_t exp_q[$];

  task automatic check(input string name, input longint got, input longint want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d want %0d", name, got, want);
  endtask

  // Bit j of the line is the j-th most significant payload bit; pad bits are zero.
  function automatic logic [NBITS-1:0] frame_of(input logic [15:0] hi, input logic [944:0] nm,
                                                input logic [15:0] hf);
    logic [976:0]     word;
    logic [NBITS-1:0] f;
    word = {hi, nm, hf};
    f = '0;
    for (int j = 0; j < 977; j++) f[j] = word[976 - j];
    return f;
  endfunction

  // Reference model: a start is taken whenever the transmitter is free; it frees TOTAL+1 edges later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_in);
      edge_no++;
      if (!rst && bus.start && edge_no >= free_at) begin
        e.bits     = frame_of(bus.handshake_i, bus.nums, bus.handshake_f);
        e.acc_edge = edge_no;
        exp_q.push_back(e);
        frames_pushed++;
        free_at = edge_no + TOTAL + 1;
      end
    end
  end

  // Monitor
  initial begin
    exp_t             cur;
    int               cyc;
    int               glitches;
    int               busy_bad;
    int               first;
    logic             per_val;
    logic [NBITS-1:0] got_bits;
    cyc = 0; glitches = 0; busy_bad = 0; per_val = 1'b0; got_bits = '0;
    forever begin
      @(negedge clk_in);
      if (rst) begin
        active = 1'b0;
      end else begin
        if (bus.trig_out) begin
          check("trig_when_expected", longint'(!active && exp_q.size() != 0), 1);
          if (!active && exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("trig_time", edge_no, cur.acc_edge);
            active = 1'b1;
            cyc = 0; glitches = 0; busy_bad = 0; got_bits = '0;
          end
        end
        if (active) begin
          if (cyc < TOTAL) begin
            if (cyc % BC == 0) per_val = bus.out;
            else if (bus.out !== per_val) glitches++;
            if (cyc % BC == BC / 2) got_bits[cyc / BC] = bus.out;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0) busy_bad++;
            cyc++;
          end else begin
            check("done_pulse", bus.done, 1);
            check("busy_fall", bus.busy, 0);
            check("period_const", glitches, 0);
            check("busy_high", busy_bad, 0);
            n_checks++;
            if (got_bits === cur.bits) n_pass++;
            else begin
              first = 0;
              for (int j = NBITS - 1; j >= 0; j--) if (got_bits[j] !== cur.bits[j]) first = j;
              $display("FAIL frame_bits: first bad bit %0d got %b want %b",
                       first, got_bits[first], cur.bits[first]);
            end
            active = 1'b0;
            frames_seen++;
          end
        end else if (!bus.trig_out) begin
          if (bus.out !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) idle_bad++;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
    #1;
  endtask

  task automatic rand_payload();
    bus.handshake_i = 16'($urandom);
    bus.handshake_f = 16'($urandom);
    for (int i = 0; i < 945; i++) bus.nums[i] = 1'($urandom_range(0, 1));
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_free();
    while (edge_no + 1 < free_at) tick(1);
    tick($urandom_range(0, 3));
  endtask

  task automatic check_outputs_low(input string tag);
    check({tag, "_out"}, bus.out, 0);
    check({tag, "_trig"}, bus.trig_out, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
  endtask

  task automatic reset_mid();
    @(posedge clk_in);
    #2;
    rst = 1'b1;
    #1;
    check_outputs_low("abort");
    exp_q.delete();
    @(negedge clk_in);
    @(negedge clk_in);
    #1;
    rand_payload();
    free_at   = 0;
    rst       = 1'b0;
    pulse_start();
  endtask

  initial begin
    int pushed_before;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.handshake_i = '0;
    bus.handshake_f = '0;
    bus.nums = '0;
    @(negedge clk_in);
    check_outputs_low("reset");
    tick(2);
    rst = 1'b0;

    // Known pattern, then a ignored re-start with changed inputs around bit 100
    bus.handshake_i = 16'hA5C3;
    bus.handshake_f = 16'h3CA5;
    bus.nums[944:910] = 35'h4_0000_0001;
    pulse_start();
    tick(100 * BC);
    rand_payload();
    pulse_start();
    wait_free();

    // All-ones payload
    bus.handshake_i = '1;
    bus.handshake_f = '1;
    bus.nums = '1;
    pulse_start();
    wait_free();

    // Random frame aborted near bit 500, then a fresh frame on the first edge after reset
    rand_payload();
    pulse_start();
    tick(500 * BC - 2);
    reset_mid();
    wait_free();

    // start held high: frames must repeat with a single idle cycle
    rand_payload();
    pushed_before = frames_pushed;
    bus.start = 1'b1;
    for (int i = 0; i < 3 * (TOTAL + 1); i++) begin
      bus.handshake_i = 16'($urandom);
      bus.handshake_f = 16'($urandom);
      tick(1);
    end
    bus.start = 1'b0;
    check("held_frames", frames_pushed - pushed_before, 3);
    wait_free();

    for (int f = 0; f < 2; f++) begin
      rand_payload();
      pulse_start();
      wait_free();
    end

    for (int i = 0; i < 2 * TOTAL && (exp_q.size() != 0 || active); i++) tick(1);
    tick(2);
    check("drain", longint'(exp_q.size() != 0 || active), 0);
    check("frames_seen", frames_seen, frames_pushed - 1);
    check("idle_quiet", idle_bad, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed so far", n_pass, n_checks);
    $fatal(1);
  end
endmodule
